gpu_rect_loader: RTL and testbench

- Frame-start DMA stage directly upstream of the five per-field gpu_mem instances: x, y, width, height, color.
- Triggered once per frame (vblank start). Streams RECT_COUNT rectangle descriptors out of synchronous-read data memory and writes each field into its gpu_mem bank, one word per cycle.
- Completes well before active video, so the rasterizer reads a stable rect table for the whole frame.

---
 rtl/gpu_rect_loader_pkg.sv | 44 ++++
 rtl/gpu_rect_loader.sv | 139 +++++++++++++
 tb/tb_gpu_rect_loader.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/gpu_rect_loader_pkg.sv
// Shared constants, field indices and loader state type for the rect loader.
// RECT_COUNT / RECT_COUNT_WIDTH may be overridden by defining the macros of the same name.
`ifndef RECT_COUNT
`define RECT_COUNT 64
`endif
`ifndef RECT_COUNT_WIDTH
`define RECT_COUNT_WIDTH 6
`endif

package gpu_rect_loader_pkg;

  localparam int RECT_COUNT       = `RECT_COUNT;
  localparam int RECT_COUNT_WIDTH = `RECT_COUNT_WIDTH;
  localparam int FIELDS           = 5;

  typedef logic [2:0] field_t;

  localparam field_t FIELD_X     = 3'd0;
  localparam field_t FIELD_Y     = 3'd1;
  localparam field_t FIELD_W     = 3'd2;
  localparam field_t FIELD_H     = 3'd3;
  localparam field_t FIELD_COLOR = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT_RD,
    ST_COUNT_LATCH,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic [FIELDS-1:0] field_onehot(input field_t f);
    case (f)
      FIELD_X:     return 5'b00001;
      FIELD_Y:     return 5'b00010;
      FIELD_W:     return 5'b00100;
      FIELD_H:     return 5'b01000;
      FIELD_COLOR: return 5'b10000;
      default:     return '0;
    endcase
  endfunction

endpackage

// File: rtl/gpu_rect_loader.sv
// Frame-start DMA: streams rect descriptors from data memory into the five gpu_mem field banks.
// Optional GPU_LOADER_COUNT_EN: first word is an active-rect count; rects beyond it are zero-filled.
module gpu_rect_loader
  import gpu_rect_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        mem_rd,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic [DATA_WIDTH-1:0]       mem_dout,
  output logic [FIELDS-1:0]           gpu_we,
  output logic [RECT_COUNT_WIDTH-1:0] gpu_addr,
  output logic [DATA_WIDTH-1:0]       gpu_din,
  output logic                        busy,
  output logic                        done
);

  state_t                      state, state_nx;
  logic [RECT_COUNT_WIDTH-1:0] rect_idx;
  field_t                      field_idx;
  logic [ADDR_WIDTH-1:0]       addr_cnt;
  logic                        pipe_vld;
  logic                        pipe_zero;
  logic [RECT_COUNT_WIDTH-1:0] pipe_rect;
  field_t                      pipe_field;
  logic                        last_issue;
  logic                        rect_active;

`ifdef GPU_LOADER_COUNT_EN
  logic [RECT_COUNT_WIDTH:0] n_active;
  assign rect_active = ({1'b0, rect_idx} < n_active);
`else
  assign rect_active = 1'b1;
`endif

  assign last_issue = (rect_idx == RECT_COUNT_WIDTH'(RECT_COUNT - 1)) && (field_idx == FIELD_COLOR);

  always_comb begin
    state_nx = state;
    mem_rd   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
`ifdef GPU_LOADER_COUNT_EN
          state_nx = ST_COUNT_RD;
`else
          state_nx = ST_LOAD;
`endif
        end
      end
      ST_COUNT_RD: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        state_nx = ST_COUNT_LATCH;
      end
      ST_COUNT_LATCH: begin
        busy     = 1'b1;
        state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        busy   = 1'b1;
        mem_rd = rect_active;
        if (last_issue) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy     = 1'b1;
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign mem_addr = mem_rd ? addr_cnt : '0;

  // Write port is decoded straight off the pipe register so it lines up with mem_dout.
  assign gpu_we   = pipe_vld ? field_onehot(pipe_field) : '0;
  assign gpu_addr = pipe_vld ? pipe_rect : '0;
  assign gpu_din  = (pipe_vld && !pipe_zero) ? mem_dout : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rect_idx   <= '0;
      field_idx  <= FIELD_X;
      addr_cnt   <= '0;
      pipe_vld   <= 1'b0;
      pipe_zero  <= 1'b0;
      pipe_rect  <= '0;
      pipe_field <= FIELD_X;
`ifdef GPU_LOADER_COUNT_EN
      n_active   <= '0;
`endif
    end else begin
      state      <= state_nx;
      pipe_vld   <= (state == ST_LOAD);
      pipe_zero  <= !rect_active;
      pipe_rect  <= rect_idx;
      pipe_field <= field_idx;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rect_idx  <= '0;
            field_idx <= FIELD_X;
            addr_cnt  <= BASE_ADDR;
          end
        end
        ST_COUNT_RD: addr_cnt <= addr_cnt + 1'b1;
        ST_COUNT_LATCH: begin
`ifdef GPU_LOADER_COUNT_EN
          if (mem_dout > DATA_WIDTH'(RECT_COUNT)) n_active <= (RECT_COUNT_WIDTH + 1)'(RECT_COUNT);
          else                                    n_active <= mem_dout[RECT_COUNT_WIDTH:0];
`endif
        end
        ST_LOAD: begin
          addr_cnt <= addr_cnt + 1'b1;
          if (field_idx == FIELD_COLOR) begin
            field_idx <= FIELD_X;
            rect_idx  <= rect_idx + 1'b1;
          end else begin
            field_idx <= field_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_rect_loader.sv
// Scoreboard bench for gpu_rect_loader: randomized memory images, reference model of the
// expected bank writes, and a per-cycle monitor for strobes, busy/done timing and invariants.
module tb_gpu_rect_loader;
  import gpu_rect_loader_pkg::*;

  localparam logic [15:0] BASE = 16'hFFFE;
  localparam int NW = RECT_COUNT * FIELDS;
`ifdef GPU_LOADER_COUNT_EN
  localparam int OFF = 2;
  localparam int OFFW = 1;
`else
  localparam int OFF = 0;
  localparam int OFFW = 0;
`endif
  localparam int FIRST_WR = 2 + OFF;
  localparam int DONE_CYC = NW + 2 + OFF;

  typedef struct {
    logic [FIELDS-1:0]           we;
    logic [RECT_COUNT_WIDTH-1:0] addr;
    logic [15:0]                 din;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_dout = '0;
  logic [FIELDS-1:0] gpu_we;
  logic [RECT_COUNT_WIDTH-1:0] gpu_addr;
  logic [15:0] gpu_din;
  logic busy, done;

  logic [15:0] mem [0:65535];
  wr_t exp_q[$];
  int cyc = 0;
  int t0 = 0;
  bit active = 1'b0;
  int cur_n = RECT_COUNT;
  int tests = 0;
  int fails = 0;

  gpu_rect_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_din(gpu_din),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd) mem_dout <= mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp, input int rel);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s rel=%0d got=%0h exp=%0h", name, rel, got, exp);
    end
  endtask

  task automatic check_cycle();
    int rel;
    bit exp_busy, exp_done, exp_rd, exp_wr;
    logic [15:0] exp_addr;
    wr_t e;
    rel = cyc - t0;
    exp_busy = active && rel >= 1 && rel < DONE_CYC;
    exp_done = active && rel == DONE_CYC;
    exp_wr   = active && rel >= FIRST_WR && rel < FIRST_WR + NW;
`ifdef GPU_LOADER_COUNT_EN
    exp_rd   = active && (rel == 1 || (rel >= 3 && rel - 3 < cur_n * FIELDS));
    exp_addr = (rel == 1) ? BASE : 16'(BASE + 16'(rel - 2));
`else
    exp_rd   = active && rel >= 1 && rel <= NW;
    exp_addr = 16'(BASE + 16'(rel - 1));
`endif
    chk("we_onehot", 32'($countones(gpu_we) <= 1), 32'd1, rel);
    if (!busy) chk("we_idle", 32'(gpu_we), 32'd0, rel);
    chk("busy", 32'(busy), 32'(exp_busy), rel);
    chk("done", 32'(done), 32'(exp_done), rel);
    chk("mem_rd", 32'(mem_rd), 32'(exp_rd), rel);
    if (mem_rd && exp_rd) chk("mem_addr", 32'(mem_addr), 32'(exp_addr), rel);
    chk("wr_present", 32'(gpu_we != 0), 32'(exp_wr), rel);
    if (gpu_we != 0) begin
      if (exp_q.size() == 0) begin
        chk("wr_extra", 32'd1, 32'd0, rel);
      end else begin
        e = exp_q.pop_front();
        chk("gpu_we", 32'(gpu_we), 32'(e.we), rel);
        chk("gpu_addr", 32'(gpu_addr), 32'(e.addr), rel);
        chk("gpu_din", 32'(gpu_din), 32'(e.din), rel);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) check_cycle();
    end
  end

  // Reference: slot i is rect i/5, field i%5, sourced from descriptor word i (zero past the count).
  task automatic load_model(input bit pat, input int cnt);
    wr_t e;
    int r;
`ifdef GPU_LOADER_COUNT_EN
    mem[BASE] = 16'(cnt);
    cur_n = (cnt > RECT_COUNT) ? RECT_COUNT : cnt;
`else
    cur_n = RECT_COUNT;
    if (cnt < 0) cur_n = 0;
`endif
    for (int k = 0; k < NW; k++)
      mem[16'(BASE + 16'(OFFW + k))] = pat ? 16'(k) : 16'($urandom);
    exp_q.delete();
    for (int i = 0; i < NW; i++) begin
      r = i / FIELDS;
      e.we   = FIELDS'(1) << (i % FIELDS);
      e.addr = RECT_COUNT_WIDTH'(r);
      e.din  = (r < cur_n) ? mem[16'(BASE + 16'(OFFW + i))] : 16'h0000;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_load(input bit pat, input int cnt, input int restart_at, input int reset_at);
    @(negedge clk); #2;
    load_model(pat, cnt);
    t0 = cyc;
    active = 1'b1;
    start = 1'b1;
    @(negedge clk); #2;
    for (int rel = 1; rel <= DONE_CYC + 4; rel++) begin
      start = (rel == restart_at);
      if (rel == reset_at) begin
        reset = 1'b1;
        #1;
        chk("rst_we", 32'(gpu_we), 32'd0, rel);
        chk("rst_rd", 32'(mem_rd), 32'd0, rel);
        chk("rst_busy", 32'(busy), 32'd0, rel);
        chk("rst_done", 32'(done), 32'd0, rel);
        active = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b0;
        return;
      end
      @(negedge clk); #2;
    end
    start = 1'b0;
    chk("q_drained", 32'(exp_q.size()), 32'd0, DONE_CYC + 4);
    active = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_we", 32'(gpu_we), 32'd0, 0);
    chk("reset_rd", 32'(mem_rd), 32'd0, 0);
    chk("reset_busy", 32'(busy), 32'd0, 0);
    chk("reset_done", 32'(done), 32'd0, 0);
    #2 reset = 1'b0;

    run_load(1'b1, 64, 0, 0);
    run_load(1'b0, 3, 100, 0);
    run_load(1'b0, 200, 0, 50);
    run_load(1'b0, 200, 0, 0);
    run_load(1'b0, 0, DONE_CYC, 0);
    for (int i = 0; i < 3; i++) run_load(1'b0, int'($urandom_range(0, 80)), 0, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
